// File: rtl/pwm_capture.sv
`default_nettype none
// =====================================================================
// pwm_capture : measures PWM high time / period, flags a stuck line
// Option PWM_CAPTURE_GLITCH_FILTER_EN : 3-cycle stability filter on input
// Revision    : 1.0
// =====================================================================
module pwm_capture #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W:0]   high_time,
  output logic [CNT_W:0]   period,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam int W = CNT_W + 1;
  localparam logic [W-1:0] C_TMO_LAST = W'(TIMEOUT - 1);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam logic [2:0] C_WARM = 3'd6;
`else
  localparam logic [2:0] C_WARM = 3'd3;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  logic         sync1_q, sync2_q, s_d_q;
  logic [2:0]   warm_q;
  logic         w_s, w_armed, w_rise, w_fall;
  state_t       state_q;
  logic [W-1:0] per_q, hi_q, tmo_q;
  logic [W-1:0] w_per_inc, w_hi_inc;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic h1_q, h2_q, filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q   <= 1'b0;
      h2_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      h1_q <= sync2_q;
      h2_q <= h1_q;
      if (sync2_q == h1_q && h1_q == h2_q) filt_q <= sync2_q;
    end
  end

  assign w_s = filt_q;
`else
  assign w_s = sync2_q;
`endif

  // Edges are ignored until the pipeline holds only real samples, so a line
  // already high at reset release is not taken for a rise.
  assign w_armed   = (warm_q == C_WARM);
  assign w_rise    = w_armed &  w_s & ~s_d_q;
  assign w_fall    = w_armed & ~w_s &  s_d_q;
  assign w_per_inc = (per_q == '1) ? per_q : per_q + 1'b1;
  assign w_hi_inc  = (hi_q  == '1) ? hi_q  : hi_q  + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_d_q   <= 1'b0;
      warm_q  <= 3'd0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      s_d_q   <= w_s;
      if (!w_armed) warm_q <= warm_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      per_q     <= '0;
      hi_q      <= '0;
      tmo_q     <= '0;
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      stuck_lvl <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_rise) begin
            per_q   <= {{(W-1){1'b0}}, 1'b1};
            hi_q    <= {{(W-1){1'b0}}, 1'b1};
            state_q <= HIGH;
          end
        end
        HIGH: begin
          per_q <= w_per_inc;
          if (w_fall) state_q <= LOW;
          else        hi_q    <= w_hi_inc;
        end
        LOW: begin
          if (w_rise) begin
            period    <= per_q;
            high_time <= hi_q;
            valid     <= 1'b1;
            per_q     <= {{(W-1){1'b0}}, 1'b1};
            hi_q      <= {{(W-1){1'b0}}, 1'b1};
            state_q   <= HIGH;
          end else begin
            per_q <= w_per_inc;
          end
        end
        default: state_q <= IDLE;
      endcase

      // An edge always beats an expiring timeout; tmo_q freezes while stuck.
      if (w_rise || w_fall) begin
        tmo_q <= '0;
        stuck <= 1'b0;
      end else if (!stuck) begin
        if (tmo_q == C_TMO_LAST) begin
          stuck     <= 1'b1;
          stuck_lvl <= w_s;
          high_time <= w_s ? '1 : '0;
          period    <= '0;
          valid     <= 1'b1;
          state_q   <= IDLE;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// Bench for pwm_capture: waveform-level reference model plus literal pins.
module tb_pwm_capture;

  localparam int CNT_W   = 10;
  localparam int TIMEOUT = 1536;
  localparam int W       = CNT_W + 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT   = 5;
  localparam int WARMK = 6;
`else
  localparam int LAT   = 2;
  localparam int WARMK = 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] high_time, period;
  logic         valid, stuck, stuck_lvl;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .high_time(high_time), .period(period),
    .valid(valid), .stuck(stuck), .stuck_lvl(stuck_lvl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works on the sampled waveform: s is the input delayed by the
  // synchronizer latency; a report covers the span between two rises.
  bit           ph[$];
  int           m_k, m_e, m_r, m_hacc;
  bit           m_meas, m_fs, m_s, m_sd, m_rise, m_fall;
  int           m_hi, m_per;
  bit           m_valid, m_stuck, m_lvl;

  function automatic bit pv(input int i);
    return (i < ph.size()) ? ph[i] : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph.delete();
      m_k = 0; m_e = 0; m_r = 0; m_hacc = 0;
      m_meas = 0; m_fs = 0;
      m_hi = 0; m_per = 0; m_valid = 0; m_stuck = 0; m_lvl = 0;
    end else begin
      m_k++;
      ph.push_front(pwm_in);
      if (ph.size() > 8) void'(ph.pop_back());
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      m_sd = m_fs;
      m_s  = (pv(3) == pv(4) && pv(4) == pv(5)) ? pv(3) : m_fs;
      m_fs = m_s;
`else
      m_s  = pv(2);
      m_sd = pv(3);
`endif
      m_rise  = (m_k > WARMK) && m_s && !m_sd;
      m_fall  = (m_k > WARMK) && !m_s && m_sd;
      m_valid = 0;
      if (m_rise || m_fall) begin
        m_e = m_k;
        m_stuck = 0;
      end else if (!m_stuck && (m_k - m_e == TIMEOUT)) begin
        m_stuck = 1; m_lvl = m_s;
        m_hi = m_s ? (1 << W) - 1 : 0;
        m_per = 0; m_valid = 1; m_meas = 0;
      end
      if (m_rise) begin
        if (m_meas) begin
          m_hi = m_hacc; m_per = m_k - m_r; m_valid = 1;
        end
        m_meas = 1; m_r = m_k; m_hacc = 0;
      end
      if (m_meas) m_hacc += int'(m_s);
    end
  end

  // ---------------- compare process ----------------
  int dut_nvalid = 0;
  int dut_last_hi = 0, dut_last_per = 0, dut_prev_hi = 0, dut_prev_per = 0;
  int stuck_cyc = 0;

  always @(negedge clk) begin
    chk("valid", int'(valid), int'(m_valid));
    chk("high_time", int'(high_time), m_hi);
    chk("period", int'(period), m_per);
    chk("stuck", int'(stuck), int'(m_stuck));
    if (m_stuck) chk("stuck_lvl", int'(stuck_lvl), int'(m_lvl));
    if (valid) begin
      dut_nvalid++;
      dut_prev_hi  = dut_last_hi;
      dut_prev_per = dut_last_per;
      dut_last_hi  = int'(high_time);
      dut_last_per = int'(period);
      if (stuck) stuck_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  task automatic pat(input int hi, input int lo, input int n);
    repeat (n) begin
      drive(1'b1, hi);
      drive(1'b0, lo);
    end
  endtask

  task automatic lit_report(input string nm, input int hi, input int per);
    chk({nm, "_dut_hi"}, dut_last_hi, hi);
    chk({nm, "_dut_per"}, dut_last_per, per);
    chk({nm, "_mdl_hi"}, m_hi, hi);
    chk({nm, "_mdl_per"}, m_per, per);
  endtask

  int v0, t_fall;
  bit lvl;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_high_time", int'(high_time), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_stuck", int'(stuck), 0);
    chk("rst_stuck_lvl", int'(stuck_lvl), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 10);

    v0 = dut_nvalid;
    pat(301, 723, 3);
    chk("p1_count", dut_nvalid - v0, 2);
    lit_report("p1", 301, 1024);

    pat(1, 1023, 2);
    lit_report("p2", 1, 1024);
    pat(1023, 1, 2);
    drive(1'b1, 301);
    lit_report("p3", 1023, 1024);

    // stuck low
    v0 = dut_nvalid;
    @(negedge clk);
    pwm_in = 1'b0;
    t_fall = cyc + 1;
    drive(1'b0, 1999);
    chk("sl_count", dut_nvalid - v0, 1);
    chk("sl_stuck", int'(stuck), 1);
    chk("sl_lvl", int'(stuck_lvl), 0);
    lit_report("sl", 0, 0);
    chk("sl_delay", stuck_cyc - t_fall, TIMEOUT + LAT);

    v0 = dut_nvalid;
    pat(301, 723, 2);
    drive(1'b1, 10);
    chk("rec_count", dut_nvalid - v0, 2);
    chk("rec_stuck", int'(stuck), 0);
    lit_report("rec", 301, 1024);

    // stuck high
    v0 = dut_nvalid;
    drive(1'b1, 2000);
    chk("sh_count", dut_nvalid - v0, 1);
    chk("sh_stuck", int'(stuck), 1);
    chk("sh_lvl", int'(stuck_lvl), 1);
    lit_report("sh", 2047, 0);

    // reset in the middle of a high phase
    drive(1'b0, 723);
    pat(301, 723, 2);
    drive(1'b1, 100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_high_time", int'(high_time), 0);
    chk("mrst_period", int'(period), 0);
    chk("mrst_stuck", int'(stuck), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = dut_nvalid;
    drive(1'b1, 201);
    drive(1'b0, 723);
    chk("mrst_partial", dut_nvalid - v0, 0);
    pat(301, 723, 1);
    drive(1'b1, 10);
    chk("mrst_count", dut_nvalid - v0, 1);
    lit_report("mrst", 301, 1024);

    // 2-cycle low glitch inside a 301-cycle high phase
    drive(1'b0, 714);
    repeat (2) begin
      drive(1'b1, 150);
      drive(1'b0, 2);
      drive(1'b1, 149);
      drive(1'b0, 723);
    end
    drive(1'b1, 10);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    lit_report("glitch", 301, 1024);
`else
    lit_report("glitch", 149, 872);
    chk("glitch_prev_hi", dut_prev_hi, 150);
    chk("glitch_prev_per", dut_prev_per, 152);
`endif

    // randomized segments, including 1-3 cycle pulses
    lvl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) drive(lvl, $urandom_range(1, 3));
      else                           drive(lvl, $urandom_range(4, 60));
      lvl = ~lvl;
    end
    drive(1'b0, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
